// File: rtl/execute_stage_mc.sv
// Execute stage: single-cycle ALU plus an iterative shift-add multiplier between decode and memory.
// Build option MUL_EARLY_OUT_EN: a multiply retires as soon as its remaining multiplier bits are zero.
module execute_stage_mc #(
  parameter int ALU_OP_W      = 3,
  parameter int IMM_W         = 32,
  parameter int DATA_W        = 32,
  parameter int ADDR_W        = 5,
  parameter int PC_W          = 32,
  parameter int MUL_STEP_BITS = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic                flush_i,
  input  logic                has_imm_i,
  input  logic [ALU_OP_W-1:0] alu_op_i,
  input  logic                alu_alt_i,
  input  logic                is_mul_i,
  input  logic                rf_we_i,
  input  logic                mem_we_i,
  input  logic                mem2rf_i,
  input  logic                branch_i,
  input  logic                check_eq_i,
  input  logic [IMM_W-1:0]    imm32_i,
  input  logic [DATA_W-1:0]   rf_data0_i,
  input  logic [DATA_W-1:0]   rf_data1_i,
  input  logic [ADDR_W-1:0]   rf_waddr_i,
  input  logic [PC_W-1:0]     pc_plus1_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic                rf_we_o,
  output logic                mem_we_o,
  output logic                mem2rf_o,
  output logic                branch_o,
  output logic                check_eq_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic [ADDR_W-1:0]   rf_waddr_o,
  output logic [DATA_W-1:0]   alu_result_o,
  output logic [PC_W-1:0]     pc_branch_o,
  output logic                busy_o
);
  localparam int N     = DATA_W / MUL_STEP_BITS;
  localparam int CNT_W = $clog2(N + 1);
  localparam int SH_W  = $clog2(DATA_W);

  typedef enum logic {S_IDLE = 1'b0, S_MUL = 1'b1} state_t;

  // Both ports: a word moves on a rising edge where valid && ready; the sender holds it while valid && !ready.
  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  mcand_q, mcand_d, mplier_q, mplier_d, prod_q, prod_d;
  logic [4:0]         pend_ctl_q, pend_ctl_d;
  logic [ADDR_W-1:0]  pend_waddr_q, pend_waddr_d;
  logic [DATA_W-1:0]  pend_wdata_q, pend_wdata_d;
  logic [PC_W-1:0]    pend_pcb_q, pend_pcb_d;
  logic               out_valid_q, out_valid_d;
  logic [4:0]         out_ctl_q, out_ctl_d;
  logic [ADDR_W-1:0]  out_waddr_q, out_waddr_d;
  logic [DATA_W-1:0]  out_wdata_q, out_wdata_d, out_result_q, out_result_d;
  logic [PC_W-1:0]    out_pcb_q, out_pcb_d;

  logic [DATA_W-1:0]  src_a, src_b, alu_res, partial, mul_sum, mul_result;
  logic [SH_W-1:0]    shamt;
  logic [PC_W-1:0]    pc_branch;
  logic [4:0]         in_ctl;
  logic               slot_free, accept, step_last, mul_fin;

  assign src_a     = rf_data0_i;
  assign src_b     = has_imm_i ? DATA_W'(imm32_i) : rf_data1_i;
  assign shamt     = src_b[SH_W-1:0];
  assign pc_branch = PC_W'(pc_plus1_i) + PC_W'(imm32_i);
  assign in_ctl    = {rf_we_i, mem_we_i, mem2rf_i, branch_i, check_eq_i};

  assign slot_free  = !out_valid_q || out_ready_i;
  assign in_ready_o = (state_q == S_IDLE) && slot_free && !flush_i;
  assign accept     = in_valid_i && in_ready_o;
  assign busy_o     = (state_q == S_MUL);

  always_comb begin
    alu_res = '0;
    case (alu_op_i)
      ALU_OP_W'(0): alu_res = alu_alt_i ? src_a - src_b : src_a + src_b;
      ALU_OP_W'(1): alu_res = src_a << shamt;
      ALU_OP_W'(2): alu_res = DATA_W'($signed(src_a) < $signed(src_b));
      ALU_OP_W'(3): alu_res = DATA_W'(src_a < src_b);
      ALU_OP_W'(4): alu_res = src_a ^ src_b;
      ALU_OP_W'(5): alu_res = alu_alt_i ? DATA_W'($signed(src_a) >>> shamt) : src_a >> shamt;
      ALU_OP_W'(6): alu_res = src_a | src_b;
      ALU_OP_W'(7): alu_res = src_a & src_b;
      default:      alu_res = '0;
    endcase
  end

  // One iteration adds the multiplicand, pre-shifted per position, for each of the low step bits.
  always_comb begin
    partial = '0;
    for (int k = 0; k < MUL_STEP_BITS; k++) begin
      if (mplier_q[k]) partial = partial + (mcand_q << k);
    end
  end

  assign mul_sum = prod_q + partial;

`ifdef MUL_EARLY_OUT_EN
  assign step_last = (cnt_q != '0) &&
                     ((cnt_q == CNT_W'(1)) || ((mplier_q >> MUL_STEP_BITS) == '0));
`else
  assign step_last = (cnt_q == CNT_W'(1));
`endif

  // Counter 0 while in MUL means the product is complete and waiting for the output slot.
  assign mul_fin    = (cnt_q == '0) || step_last;
  assign mul_result = (cnt_q == '0) ? prod_q : mul_sum;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    mcand_d      = mcand_q;
    mplier_d     = mplier_q;
    prod_d       = prod_q;
    pend_ctl_d   = pend_ctl_q;
    pend_waddr_d = pend_waddr_q;
    pend_wdata_d = pend_wdata_q;
    pend_pcb_d   = pend_pcb_q;
    out_valid_d  = out_valid_q;
    out_ctl_d    = out_ctl_q;
    out_waddr_d  = out_waddr_q;
    out_wdata_d  = out_wdata_q;
    out_result_d = out_result_q;
    out_pcb_d    = out_pcb_q;

    if (out_valid_q && out_ready_i) begin
      out_valid_d = 1'b0;
      out_ctl_d   = '0;
    end

    if (flush_i) begin
      out_valid_d = 1'b0;
      out_ctl_d   = '0;
      state_d     = S_IDLE;
      cnt_d       = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            if (is_mul_i) begin
              state_d      = S_MUL;
              cnt_d        = CNT_W'(N);
              mcand_d      = src_a;
              mplier_d     = src_b;
              prod_d       = '0;
              pend_ctl_d   = in_ctl;
              pend_waddr_d = rf_waddr_i;
              pend_wdata_d = rf_data1_i;
              pend_pcb_d   = pc_branch;
            end else begin
              out_valid_d  = 1'b1;
              out_ctl_d    = in_ctl;
              out_waddr_d  = rf_waddr_i;
              out_wdata_d  = rf_data1_i;
              out_result_d = alu_res;
              out_pcb_d    = pc_branch;
            end
          end
        end
        S_MUL: begin
          mcand_d  = mcand_q << MUL_STEP_BITS;
          mplier_d = mplier_q >> MUL_STEP_BITS;
          if (mul_fin) begin
            cnt_d = '0;
            if (slot_free) begin
              state_d      = S_IDLE;
              out_valid_d  = 1'b1;
              out_ctl_d    = pend_ctl_q;
              out_waddr_d  = pend_waddr_q;
              out_wdata_d  = pend_wdata_q;
              out_result_d = mul_result;
              out_pcb_d    = pend_pcb_q;
            end else begin
              prod_d = mul_result;
            end
          end else begin
            prod_d = mul_sum;
            cnt_d  = cnt_q - CNT_W'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      mcand_q      <= '0;
      mplier_q     <= '0;
      prod_q       <= '0;
      pend_ctl_q   <= '0;
      pend_waddr_q <= '0;
      pend_wdata_q <= '0;
      pend_pcb_q   <= '0;
      out_valid_q  <= 1'b0;
      out_ctl_q    <= '0;
      out_waddr_q  <= '0;
      out_wdata_q  <= '0;
      out_result_q <= '0;
      out_pcb_q    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mcand_q      <= mcand_d;
      mplier_q     <= mplier_d;
      prod_q       <= prod_d;
      pend_ctl_q   <= pend_ctl_d;
      pend_waddr_q <= pend_waddr_d;
      pend_wdata_q <= pend_wdata_d;
      pend_pcb_q   <= pend_pcb_d;
      out_valid_q  <= out_valid_d;
      out_ctl_q    <= out_ctl_d;
      out_waddr_q  <= out_waddr_d;
      out_wdata_q  <= out_wdata_d;
      out_result_q <= out_result_d;
      out_pcb_q    <= out_pcb_d;
    end
  end

  assign out_valid_o  = out_valid_q;
  assign {rf_we_o, mem_we_o, mem2rf_o, branch_o, check_eq_o} = out_ctl_q;
  assign rf_waddr_o   = out_waddr_q;
  assign mem_wdata_o  = out_wdata_q;
  assign alu_result_o = out_result_q;
  assign pc_branch_o  = out_pcb_q;
endmodule
